// File: rtl/lfsr_ctrl_pkg.sv
// Shared constants for the lfsr_galois sequencer and its datapath.
// State encoding, default widths, zero-seed substitute and LFSR taps.
package lfsr_ctrl_pkg;

    localparam int NB_LFSR_DFLT = 8;

    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;
    localparam logic [7:0] LFSR_POLY8    = 8'hB8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_RUN     = 3'd3;
    localparam state_t ST_DRAIN   = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/lfsr_galois.sv
// Right-shift Galois LFSR datapath driven by lfsr_galois_ctrl.
// Soft reset loads the seed; valid advances one step.
module lfsr_galois
    import lfsr_ctrl_pkg::*;
#(
    parameter int               NB   = NB_LFSR_DFLT,
    parameter logic [NB-1:0]    POLY = LFSR_POLY8
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic [NB-1:0] i_seed,
    input  logic          i_soft_reset,
    input  logic          i_valid,
    output logic [NB-1:0] o_lfsr
);

    logic [NB-1:0] lfsr_q;
    logic [NB-1:0] lfsr_d;

    // Seed load takes priority over an advance
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_soft_reset) begin
            lfsr_d = i_seed;
        end else if (i_valid) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
        end
    end

    // State register; hard reset parks on a non-locking value
    always_ff @(posedge clk) begin
        if (i_rst) begin
            lfsr_q <= NB'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_lfsr = lfsr_q;

endmodule

// File: rtl/lfsr_period_meter.sv
// Captures the reference word and counts advances until it reappears.
// The counter saturates; a match after saturation is dropped.
module lfsr_period_meter
    import lfsr_ctrl_pkg::*;
#(
    parameter int NB_LFSR   = NB_LFSR_DFLT,
    parameter int NB_PERIOD = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_capture,
    input  logic                 i_word_valid,
    input  logic [NB_LFSR-1:0]   i_word,
    output logic [NB_PERIOD-1:0] o_period,
    output logic                 o_period_ok
);

    localparam logic [NB_PERIOD-1:0] CNT_MAX = '1;

    logic [NB_LFSR-1:0]   ref_q;
    logic [NB_LFSR-1:0]   ref_d;
    logic [NB_PERIOD-1:0] cnt_q;
    logic [NB_PERIOD-1:0] cnt_d;
    logic [NB_PERIOD-1:0] period_q;
    logic [NB_PERIOD-1:0] period_d;
    logic                 ok_q;
    logic                 ok_d;
    logic                 cnt_sat;
    logic                 match;

    assign cnt_sat = (cnt_q == CNT_MAX);
    assign match   = i_word_valid && !ok_q && !cnt_sat
                     && (i_word == ref_q);

    // Only the first repeat of the reference is recorded
    always_comb begin
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        ok_d     = ok_q;
        if (i_clear) begin
            cnt_d    = '0;
            period_d = '0;
            ok_d     = 1'b0;
        end else begin
            if (i_capture) begin
                ref_d = i_word;
            end
            if (i_word_valid && !cnt_sat) begin
                cnt_d = cnt_q + NB_PERIOD'(1);
            end
            if (match) begin
                period_d = cnt_q + NB_PERIOD'(1);
                ok_d     = 1'b1;
            end
        end
    end

    // Meter registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            ref_q    <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            ok_q     <= 1'b0;
        end else begin
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            ok_q     <= ok_d;
        end
    end

    assign o_period    = period_q;
    assign o_period_ok = ok_q;

endmodule

// File: rtl/lfsr_galois_ctrl.sv
// Sequencer for one lfsr_galois: seed load, bounded burst, period measure.
// LFSR_CTRL_CONT_EN: burst length 0 runs until abort.
module lfsr_galois_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int NB_LFSR   = NB_LFSR_DFLT,
    parameter int NB_BURST  = 16,
    parameter int NB_PERIOD = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NB_LFSR-1:0]   i_seed,
    input  logic [NB_BURST-1:0]  i_burst_len,
    input  logic [NB_LFSR-1:0]   i_lfsr,
    output logic [NB_LFSR-1:0]   o_lfsr_seed,
    output logic                 o_lfsr_soft_reset,
    output logic                 o_lfsr_valid,
    output logic [NB_LFSR-1:0]   o_word,
    output logic                 o_word_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NB_PERIOD-1:0] o_period,
    output logic                 o_period_ok
);

    state_t                state_q;
    state_t                state_d;
    logic [NB_LFSR-1:0]    seed_q;
    logic [NB_LFSR-1:0]    seed_d;
    logic [NB_BURST-1:0]   burst_q;
    logic [NB_BURST-1:0]   burst_d;
    logic                  cont_q;
    logic                  cont_d;
    logic                  soft_reset_q;
    logic                  soft_reset_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  word_valid_q;
    logic                  word_valid_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;
    logic                  last_adv;

    // Last bounded advance; never true in continuous mode
    assign last_adv = !cont_q && (burst_q == NB_BURST'(1));

    // Next state, seed/length latches and burst down-counter
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        burst_d = burst_q;
        cont_d  = cont_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    burst_d = i_burst_len;
                    seed_d  = (i_seed == '0) ?
                              NB_LFSR'(ZERO_SEED_SUB) : i_seed;
`ifdef LFSR_CTRL_CONT_EN
                    cont_d  = (i_burst_len == '0);
`else
                    cont_d  = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                state_d = i_abort ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (i_abort) begin
                    state_d = ST_DONE;
                end else if (!cont_q && (burst_q == '0)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cont_q) begin
                    burst_d = burst_q - NB_BURST'(1);
                end
                // Abort still drains the word already in flight
                if (i_abort || last_adv) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered
    always_comb begin
        soft_reset_d = (state_d == ST_LOAD);
        valid_d      = (state_d == ST_RUN);
        word_valid_d = valid_q;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            seed_q       <= '0;
            burst_q      <= '0;
            cont_q       <= 1'b0;
            soft_reset_q <= 1'b0;
            valid_q      <= 1'b0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            burst_q      <= burst_d;
            cont_q       <= cont_d;
            soft_reset_q <= soft_reset_d;
            valid_q      <= valid_d;
            word_valid_q <= word_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    lfsr_period_meter #(
        .NB_LFSR   (NB_LFSR),
        .NB_PERIOD (NB_PERIOD)
    ) u_meter (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_clear      (state_d == ST_LOAD),
        .i_capture    (state_q == ST_CAPTURE),
        .i_word_valid (word_valid_q),
        .i_word       (i_lfsr),
        .o_period     (o_period),
        .o_period_ok  (o_period_ok)
    );

    assign o_lfsr_seed       = seed_q;
    assign o_lfsr_soft_reset = soft_reset_q;
    assign o_lfsr_valid      = valid_q;
    assign o_word            = i_lfsr;
    assign o_word_valid      = word_valid_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;

endmodule

// File: tb/tb_lfsr_galois_ctrl.sv
// Directed bench: lfsr_galois_ctrl driving an lfsr_galois (taps 8'hB8).
// Cycle 0 is the cycle in which i_start is held high.
module tb_lfsr_galois_ctrl;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_seed;
    logic [15:0] i_burst_len;
    logic [7:0]  lfsr_out;
    logic [7:0]  o_lfsr_seed;
    logic        o_lfsr_soft_reset;
    logic        o_lfsr_valid;
    logic [7:0]  o_word;
    logic        o_word_valid;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_period;
    logic        o_period_ok;

    int n_cmp;
    int n_err;
    int cyc;

    int sr_cnt, sr_c, v_cnt, v_first, v_last;
    int wv_cnt, wv_first, wv_last, done_c;
    logic [7:0]  seed_c1, cap_c2, w4, w5, seed_end;
    logic        busy_c1, rst_zero, post_busy, post_done, post_ok;
    logic [15:0] post_period;

    lfsr_galois_ctrl u_dut (
        .clk               (clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_abort           (i_abort),
        .i_seed            (i_seed),
        .i_burst_len       (i_burst_len),
        .i_lfsr            (lfsr_out),
        .o_lfsr_seed       (o_lfsr_seed),
        .o_lfsr_soft_reset (o_lfsr_soft_reset),
        .o_lfsr_valid      (o_lfsr_valid),
        .o_word            (o_word),
        .o_word_valid      (o_word_valid),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_period          (o_period),
        .o_period_ok       (o_period_ok)
    );

    lfsr_galois u_lfsr (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_seed       (o_lfsr_seed),
        .i_soft_reset (o_lfsr_soft_reset),
        .i_valid      (o_lfsr_valid),
        .o_lfsr       (lfsr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input logic [7:0] seed, input logic [15:0] len,
                       input logic abort0, input int abort_c,
                       input int rst_c, input int restart_c,
                       input int maxc);
        sr_cnt = 0; sr_c = -1; v_cnt = 0; v_first = -1; v_last = -1;
        wv_cnt = 0; wv_first = -1; wv_last = -1; done_c = -1;
        seed_c1 = 8'h00; cap_c2 = 8'h00; w4 = 8'h00; w5 = 8'h00;
        busy_c1 = 1'b0; rst_zero = 1'b0;
        i_seed = seed;
        i_burst_len = len;
        i_start = 1'b1;
        i_abort = abort0;
        cyc = 0;
        while (cyc < maxc) begin
            step();
            i_start = (cyc == restart_c);
            i_abort = (cyc == abort_c);
            i_rst   = (cyc == rst_c);
            if (cyc == restart_c) begin
                i_seed = 8'h3C;
                i_burst_len = 16'd5;
            end
            if (o_lfsr_soft_reset) begin
                sr_cnt++;
                sr_c = cyc;
            end
            if (o_lfsr_valid) begin
                v_cnt++;
                if (v_first < 0) v_first = cyc;
                v_last = cyc;
            end
            if (o_word_valid) begin
                wv_cnt++;
                if (wv_first < 0) wv_first = cyc;
                wv_last = cyc;
            end
            if (cyc == 1) begin
                seed_c1 = o_lfsr_seed;
                busy_c1 = o_busy;
            end
            if (cyc == 2) cap_c2 = o_word;
            if (cyc == 4) w4 = o_word;
            if (cyc == 5) w5 = o_word;
            if (cyc == rst_c + 1) begin
                rst_zero = ({o_lfsr_seed, o_lfsr_soft_reset, o_lfsr_valid,
                             o_word_valid, o_busy, o_done, o_period,
                             o_period_ok} == '0);
                break;
            end
            if (o_done) begin
                done_c = cyc;
                break;
            end
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        i_rst = 1'b0;
        seed_end = o_lfsr_seed;
        step();
        post_busy = o_busy;
        post_done = o_done;
        post_period = o_period;
        post_ok = o_period_ok;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_start = 1'b1;
        i_abort = 1'b0;
        i_seed = 8'h77;
        i_burst_len = 16'd9;
        step();
        step();
        n_cmp++;
        if ({o_lfsr_soft_reset, o_lfsr_valid, o_word_valid, o_done} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctl got %b exp 0000",
                     {o_lfsr_soft_reset, o_lfsr_valid, o_word_valid, o_done});
        end
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy got %b exp 0", o_busy);
        end
        n_cmp++;
        if (o_lfsr_seed !== 8'h00) begin
            n_err++;
            $display("FAIL reset_seed got %h exp 00", o_lfsr_seed);
        end
        n_cmp++;
        if ({o_period, o_period_ok} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_period got %h/%b exp 0000/0", o_period, o_period_ok);
        end
        i_rst = 1'b0;
        i_start = 1'b0;
        step();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy got %b exp 0", o_busy);
        end
    endtask

    task automatic test_full_period();
        run(8'h01, 16'd300, 1'b0, -1, -1, -1, 400);
        n_cmp++;
        if (sr_cnt !== 1 || sr_c !== 1) begin
            n_err++;
            $display("FAIL full_soft_reset got cnt %0d at c%0d exp 1 at c1", sr_cnt, sr_c);
        end
        n_cmp++;
        if (busy_c1 !== 1'b1 || seed_c1 !== 8'h01) begin
            n_err++;
            $display("FAIL full_c1 got busy %b seed %h exp 1/01", busy_c1, seed_c1);
        end
        n_cmp++;
        if (cap_c2 !== 8'h01) begin
            n_err++;
            $display("FAIL full_capture_word got %h exp 01", cap_c2);
        end
        n_cmp++;
        if (v_cnt !== 300 || v_first !== 3 || v_last !== 302) begin
            n_err++;
            $display("FAIL full_valid got %0d c%0d..c%0d exp 300 c3..c302", v_cnt, v_first, v_last);
        end
        n_cmp++;
        if (wv_cnt !== 300 || wv_first !== 4 || wv_last !== 303) begin
            n_err++;
            $display("FAIL full_word_valid got %0d c%0d..c%0d exp 300 c4..c303",
                     wv_cnt, wv_first, wv_last);
        end
        n_cmp++;
        if (w4 !== 8'hB8 || w5 !== 8'h5C) begin
            n_err++;
            $display("FAIL full_words got %h %h exp b8 5c", w4, w5);
        end
        n_cmp++;
        if (done_c !== 304) begin
            n_err++;
            $display("FAIL full_done got c%0d exp c304", done_c);
        end
        n_cmp++;
        if (post_period !== 16'd255 || post_ok !== 1'b1) begin
            n_err++;
            $display("FAIL full_period got %0d/%b exp 255/1", post_period, post_ok);
        end
        n_cmp++;
        if (post_busy !== 1'b0 || post_done !== 1'b0) begin
            n_err++;
            $display("FAIL full_after_done got busy %b done %b exp 0/0", post_busy, post_done);
        end
    endtask

    task automatic test_zero_seed();
        run(8'h00, 16'd10, 1'b1, -1, -1, -1, 100);
        n_cmp++;
        if (seed_c1 !== 8'h01) begin
            n_err++;
            $display("FAIL zseed_seed got %h exp 01", seed_c1);
        end
        n_cmp++;
        if (wv_cnt !== 10 || wv_first !== 4) begin
            n_err++;
            $display("FAIL zseed_word_valid got %0d from c%0d exp 10 from c4", wv_cnt, wv_first);
        end
        n_cmp++;
        if (w4 !== 8'hB8) begin
            n_err++;
            $display("FAIL zseed_word got %h exp b8", w4);
        end
        n_cmp++;
        if (done_c !== 14 || post_ok !== 1'b0) begin
            n_err++;
            $display("FAIL zseed_done got c%0d ok %b exp c14 ok 0", done_c, post_ok);
        end
    endtask

    task automatic test_zero_len();
`ifdef LFSR_CTRL_CONT_EN
        run(8'hA5, 16'd0, 1'b0, 20, -1, -1, 200);
        n_cmp++;
        if (v_cnt !== 18 || v_first !== 3 || v_last !== 20) begin
            n_err++;
            $display("FAIL cont_valid got %0d c%0d..c%0d exp 18 c3..c20", v_cnt, v_first, v_last);
        end
        n_cmp++;
        if (done_c !== 22) begin
            n_err++;
            $display("FAIL cont_done got c%0d exp c22", done_c);
        end
`else
        run(8'hA5, 16'd0, 1'b0, -1, -1, -1, 100);
        n_cmp++;
        if (v_cnt !== 0 || wv_cnt !== 0) begin
            n_err++;
            $display("FAIL zlen_valid got %0d/%0d exp 0/0", v_cnt, wv_cnt);
        end
        n_cmp++;
        if (done_c !== 3) begin
            n_err++;
            $display("FAIL zlen_done got c%0d exp c3", done_c);
        end
`endif
        n_cmp++;
        if (seed_c1 !== 8'hA5 || cap_c2 !== 8'hA5) begin
            n_err++;
            $display("FAIL zlen_seed got %h/%h exp a5/a5", seed_c1, cap_c2);
        end
    endtask

    task automatic test_abort();
        run(8'h01, 16'd300, 1'b0, 50, -1, -1, 400);
        n_cmp++;
        if (v_cnt !== 48 || v_last !== 50) begin
            n_err++;
            $display("FAIL abort_valid got %0d last c%0d exp 48 last c50", v_cnt, v_last);
        end
        n_cmp++;
        if (wv_last !== 51) begin
            n_err++;
            $display("FAIL abort_word_valid got last c%0d exp c51", wv_last);
        end
        n_cmp++;
        if (done_c !== 52 || post_ok !== 1'b0) begin
            n_err++;
            $display("FAIL abort_done got c%0d ok %b exp c52 ok 0", done_c, post_ok);
        end
    endtask

    task automatic test_rst_mid_run();
        run(8'h01, 16'd300, 1'b0, -1, 100, -1, 400);
        n_cmp++;
        if (rst_zero !== 1'b1) begin
            n_err++;
            $display("FAIL rst_outputs got %b exp 1 (all zero at c101)", rst_zero);
        end
        n_cmp++;
        if (done_c !== -1) begin
            n_err++;
            $display("FAIL rst_no_done got c%0d exp none", done_c);
        end
        run(8'h80, 16'd20, 1'b0, -1, -1, -1, 100);
        n_cmp++;
        if (done_c !== 24 || v_cnt !== 20) begin
            n_err++;
            $display("FAIL rst_rerun got c%0d %0d exp c24 20", done_c, v_cnt);
        end
        n_cmp++;
        if (w4 !== 8'h40 || w5 !== 8'h20) begin
            n_err++;
            $display("FAIL rst_rerun_words got %h %h exp 40 20", w4, w5);
        end
    endtask

    task automatic test_back_to_back();
        run(8'h5A, 16'd12, 1'b0, -1, -1, 5, 100);
        n_cmp++;
        if (seed_end !== 8'h5A) begin
            n_err++;
            $display("FAIL b2b_seed got %h exp 5a", seed_end);
        end
        n_cmp++;
        if (v_cnt !== 12 || done_c !== 16) begin
            n_err++;
            $display("FAIL b2b_len got %0d c%0d exp 12 c16", v_cnt, done_c);
        end
        n_cmp++;
        if (sr_cnt !== 1) begin
            n_err++;
            $display("FAIL b2b_soft_reset got %0d exp 1", sr_cnt);
        end
        n_cmp++;
        if (w4 !== 8'h2D || w5 !== 8'hAE) begin
            n_err++;
            $display("FAIL b2b_words got %h %h exp 2d ae", w4, w5);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_seed = 8'h00;
        i_burst_len = 16'd0;
        test_reset();
        test_full_period();
        test_zero_seed();
        test_zero_len();
        test_abort();
        test_rst_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
